// File: rtl/register_file.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port, x0 hardwired to zero.
// Optional write-through bypass from the write port to the read ports: define REGFILE_BYPASS_EN.
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WriteEnable,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   logic [DATA_W-1:0] regs [NREGS];
   logic              wr_live;

   // x0 writes are dropped here; the read muxes also force x0 to zero
   assign wr_live = WriteEnable && (rd != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[rd] <= WriteData;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Write-through: a same-cycle read of rd sees the incoming WriteData
   always_comb begin
      ReadData1 = '0;
      if (!rst && (rs1 != '0)) begin
         ReadData1 = (wr_live && (rd == rs1)) ? WriteData : regs[rs1];
      end
   end

   always_comb begin
      ReadData2 = '0;
      if (!rst && (rs2 != '0)) begin
         ReadData2 = (wr_live && (rd == rs2)) ? WriteData : regs[rs2];
      end
   end
`else
   always_comb begin
      ReadData1 = '0;
      if (!rst && (rs1 != '0)) begin
         ReadData1 = regs[rs1];
      end
   end

   always_comb begin
      ReadData2 = '0;
      if (!rst && (rs2 != '0)) begin
         ReadData2 = regs[rs2];
      end
   end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read values, a negedge monitor compares them.
module tb_register_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              WriteEnable = 1'b0;
   logic [ADDR_W-1:0] rs1 = '0;
   logic [ADDR_W-1:0] rs2 = '0;
   logic [ADDR_W-1:0] rd = '0;
   logic [DATA_W-1:0] WriteData = '0;
   logic [DATA_W-1:0] ReadData1;
   logic [DATA_W-1:0] ReadData2;

   int n_cmp = 0;
   int n_bad = 0;

   string             q_name [$];
   logic [DATA_W-1:0] q_e1 [$];
   logic [DATA_W-1:0] q_e2 [$];

   register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
      .clk(clk),
      .rst(rst),
      .WriteEnable(WriteEnable),
      .rs1(rs1),
      .rs2(rs2),
      .rd(rd),
      .WriteData(WriteData),
      .ReadData1(ReadData1),
      .ReadData2(ReadData2)
   );

   always #5 clk = ~clk;

   // Monitor: one queued expectation is checked per cycle, mid-cycle
   always @(negedge clk) begin
      if (q_name.size() > 0) begin
         string             nm;
         logic [DATA_W-1:0] e1, e2;
         nm = q_name.pop_front();
         e1 = q_e1.pop_front();
         e2 = q_e2.pop_front();
         n_cmp++;
         if (ReadData1 !== e1) begin
            n_bad++;
            $display("FAIL %s ReadData1: got %08h expected %08h", nm, ReadData1, e1);
         end
         n_cmp++;
         if (ReadData2 !== e2) begin
            n_bad++;
            $display("FAIL %s ReadData2: got %08h expected %08h", nm, ReadData2, e2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
      WriteEnable = we;
      rd          = wa;
      WriteData   = wd;
      rs1         = a1;
      rs2         = a2;
   endtask

   task automatic expect_rd(input string nm, input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
      q_name.push_back(nm);
      q_e1.push_back(e1);
      q_e2.push_back(e2);
   endtask

   function automatic logic [DATA_W-1:0] sweep_val(input int i);
      logic [DATA_W-1:0] v;
      v = 32'h0101_0101 * i;
      return (i == 0) ? '0 : v;
   endfunction

   initial begin
      // Reset state while rst is held
      tick(); drv(1'b0, 5'd0, '0, 5'd5, 5'd31); expect_rd("reset_state", 32'h0, 32'h0);
      tick(); rst = 1'b0; drv(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0); expect_rd("post_reset_x0", 32'h0, 32'h0);
      tick(); drv(1'b0, 5'd0, '0, 5'd5, 5'd5); expect_rd("load_x5", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // Asynchronous reset between edges clears x5 before the next edge
      tick(); drv(1'b0, 5'd0, '0, 5'd5, 5'd0); expect_rd("async_reset", 32'h0, 32'h0);
      #1 rst = 1'b1;
      // rst overrides a write
      tick(); drv(1'b1, 5'd6, 32'h0000_0066, 5'd6, 5'd5); expect_rd("rst_blocks_write", 32'h0, 32'h0);
      // First write commits on the first edge with rst low
      tick(); rst = 1'b0; drv(1'b1, 5'd6, 32'h0000_0066, 5'd5, 5'd5); expect_rd("rst_release", 32'h0, 32'h0);
      tick(); drv(1'b0, 5'd0, '0, 5'd6, 5'd5); expect_rd("first_write", 32'h0000_0066, 32'h0);

      // Basic write/read, same index on both ports
      tick(); drv(1'b1, 5'd7, 32'h0000_1234, 5'd0, 5'd0); expect_rd("wr_x7_cycle", 32'h0, 32'h0);
      tick(); drv(1'b0, 5'd0, '0, 5'd7, 5'd7); expect_rd("rd_x7", 32'h0000_1234, 32'h0000_1234);

      // x0 write discarded, and never bypassed
      tick(); drv(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0); expect_rd("x0_same_cycle", 32'h0, 32'h0);
      tick(); drv(1'b0, 5'd0, '0, 5'd0, 5'd7); expect_rd("x0_after", 32'h0, 32'h0000_1234);
      tick(); drv(1'b0, 5'd0, '0, 5'd6, 5'd5); expect_rd("x0_no_side", 32'h0000_0066, 32'h0);

      // Hold with WriteEnable low
      tick(); drv(1'b0, 5'd7, 32'hAAAA_AAAA, 5'd7, 5'd0); expect_rd("hold_cycle", 32'h0000_1234, 32'h0);
      tick(); drv(1'b0, 5'd0, '0, 5'd7, 5'd7); expect_rd("hold_after", 32'h0000_1234, 32'h0000_1234);

      // Same-cycle read of the register being written
      tick(); drv(1'b1, 5'd3, 32'h0000_0011, 5'd0, 5'd0); expect_rd("wr_x3", 32'h0, 32'h0);
      tick(); drv(1'b1, 5'd3, 32'h0000_0022, 5'd7, 5'd3);
      expect_rd("same_cycle", 32'h0000_1234, BYP ? 32'h0000_0022 : 32'h0000_0011);
      tick(); drv(1'b0, 5'd0, '0, 5'd3, 5'd3); expect_rd("after_edge", 32'h0000_0022, 32'h0000_0022);

      // Sweep: write x1..x31, then read every complementary pair
      for (int i = 1; i < NREGS; i++) begin
         tick(); drv(1'b1, ADDR_W'(i), sweep_val(i), 5'd0, 5'd0);
      end
      for (int i = 0; i < NREGS; i++) begin
         tick(); drv(1'b0, 5'd0, '0, ADDR_W'(i), ADDR_W'(NREGS - 1 - i));
         expect_rd($sformatf("sweep_%0d", i), sweep_val(i), sweep_val(NREGS - 1 - i));
      end

      tick(); drv(1'b0, 5'd0, '0, 5'd0, 5'd0);
      repeat (3) @(posedge clk);
      n_cmp++;
      if (q_name.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q_name.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
